// File: rtl/fir_input_buffer.sv
// -----------------------------------------------------------------------------
// fir_input_buffer
// Elastic sample buffer feeding a FIR filter. Upstream samples are written into
// a circular memory; a two-state output FSM moves the head entry into a holding
// register that the filter consumes with a single-cycle i_ready pulse. Samples
// arriving while the memory is full are dropped and counted.
//
// Ports
//   i_clk          clock, all state changes on its rising edge
//   i_rst_n        asynchronous active-low reset
//   i_en           global enable, low freezes all state
//   iv_din         signed input sample
//   i_din_valid    iv_din valid this cycle
//   o_din_ready    buffer accepts a sample this cycle
//   ov_dout        sample presented to the filter
//   o_dout_valid   ov_dout holds a valid sample
//   i_ready        consumed pulse from the filter
//   ov_level       memory occupancy 0..DEPTH (output register excluded)
//   o_full/o_empty ov_level == DEPTH / ov_level == 0
//   o_overflow     sticky, a sample has been dropped since reset
//   ov_drop_count  saturating count of dropped samples
// -----------------------------------------------------------------------------
module fir_input_buffer #(
   parameter int unsigned DATA_WIDTH = 24,
   parameter int unsigned DEPTH      = 16
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_en,
   input  logic [DATA_WIDTH-1:0]        iv_din,
   input  logic                         i_din_valid,
   output logic                         o_din_ready,
   output logic [DATA_WIDTH-1:0]        ov_dout,
   output logic                         o_dout_valid,
   input  logic                         i_ready,
   output logic [$clog2(DEPTH):0]       ov_level,
   output logic                         o_full,
   output logic                         o_empty,
   output logic                         o_overflow,
   output logic [15:0]                  ov_drop_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam logic [LW-1:0] LevelFull = LW'(DEPTH);

   typedef enum logic {StIdle, StPresent} state_e;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]         level_q, level_d;
   logic                  full_q, empty_q;
   state_e                state_q;
   logic [DATA_WIDTH-1:0] dout_q;
   logic                  overflow_q;
   logic [15:0]           drop_cnt_q;

   logic wr_en, drop_en, rd_en;

   // Flags come from registered full_q/empty_q only, so a read at the same
   // edge never frees room for a write into a full memory.
   always_comb begin
      wr_en   = i_en && i_din_valid && !full_q;
      drop_en = i_en && i_din_valid && full_q;
      // Load the output register when it is empty or being consumed.
      rd_en   = i_en && !empty_q && ((state_q == StIdle) || i_ready);
      level_d = level_q;
      case ({wr_en, rd_en})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   // Sample storage, intentionally not reset.
   always_ff @(posedge i_clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= iv_din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (rd_en) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         level_q <= level_d;
         full_q  <= (level_d == LevelFull);
         empty_q <= (level_d == '0);
      end
   end

   // Output FSM with registered data/valid.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= StIdle;
         dout_q  <= '0;
      end else if (i_en) begin
         case (state_q)
            StIdle: begin
               if (rd_en) begin
                  dout_q  <= mem_q[rd_ptr_q];
                  state_q <= StPresent;
               end
            end
            StPresent: begin
               if (i_ready) begin
                  if (rd_en) begin
                     dout_q <= mem_q[rd_ptr_q];
                  end else begin
                     state_q <= StIdle;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else if (drop_en) begin
         overflow_q <= 1'b1;
         if (drop_cnt_q != 16'hFFFF) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
         end
      end
   end

   assign o_din_ready   = i_en && !full_q;
   assign ov_dout       = dout_q;
   assign o_dout_valid  = (state_q == StPresent);
   assign ov_level      = level_q;
   assign o_full        = full_q;
   assign o_empty       = empty_q;
   assign o_overflow    = overflow_q;
   assign ov_drop_count = drop_cnt_q;

endmodule

// File: tb/tb_fir_input_buffer.sv
module tb_fir_input_buffer;

   localparam int DW    = 24;
   localparam int DEPTH = 16;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          i_clk = 1'b0;
   logic          i_rst_n;
   logic          i_en;
   logic [DW-1:0] iv_din;
   logic          i_din_valid;
   logic          o_din_ready;
   logic [DW-1:0] ov_dout;
   logic          o_dout_valid;
   logic          i_ready;
   logic [LW-1:0] ov_level;
   logic          o_full;
   logic          o_empty;
   logic          o_overflow;
   logic [15:0]   ov_drop_count;

   fir_input_buffer #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH)
   ) dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_en          (i_en),
      .iv_din        (iv_din),
      .i_din_valid   (i_din_valid),
      .o_din_ready   (o_din_ready),
      .ov_dout       (ov_dout),
      .o_dout_valid  (o_dout_valid),
      .i_ready       (i_ready),
      .ov_level      (ov_level),
      .o_full        (o_full),
      .o_empty       (o_empty),
      .o_overflow    (o_overflow),
      .ov_drop_count (ov_drop_count)
   );

   always #5 i_clk = ~i_clk;

   int compared   = 0;
   int mismatched = 0;

   // Reference model: scoreboard of samples held in memory plus output register.
   logic [DW-1:0] sb_q[$];
   logic [DW-1:0] m_out;
   logic          m_valid;
   logic          m_ovf;
   logic [15:0]   m_drop;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".valid"}, 32'(o_dout_valid), 32'(m_valid));
      chk({tag, ".level"}, 32'(ov_level), 32'(sb_q.size()));
      chk({tag, ".full"}, 32'(o_full), 32'(sb_q.size() == DEPTH));
      chk({tag, ".empty"}, 32'(o_empty), 32'(sb_q.size() == 0));
      chk({tag, ".din_ready"}, 32'(o_din_ready), 32'(i_en && (sb_q.size() != DEPTH)));
      chk({tag, ".overflow"}, 32'(o_overflow), 32'(m_ovf));
      chk({tag, ".drops"}, 32'(ov_drop_count), 32'(m_drop));
      if (m_valid) chk({tag, ".dout"}, 32'(ov_dout), 32'(m_out));
   endtask

   task automatic model_reset();
      sb_q.delete();
      m_out   = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_drop  = '0;
   endtask

   // One clock: drive inputs, predict from pre-edge model state, check after edge.
   task automatic step(input string tag, input logic en, input logic v,
                       input logic [DW-1:0] d, input logic r);
      logic acc, drp, pop;
      i_en        = en;
      i_din_valid = v;
      iv_din      = d;
      i_ready     = r;
      acc = en && v && (sb_q.size() != DEPTH);
      drp = en && v && (sb_q.size() == DEPTH);
      pop = en && (sb_q.size() != 0) && (!m_valid || r);
      @(posedge i_clk);
      #1;
      if (pop) begin
         m_out   = sb_q.pop_front();
         m_valid = 1'b1;
      end else if (en && m_valid && r) begin
         m_valid = 1'b0;
      end
      if (acc) sb_q.push_back(d);
      if (drp) begin
         m_ovf = 1'b1;
         if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end
      check_all(tag);
   endtask

   initial begin
      i_rst_n     = 1'b0;
      i_en        = 1'b0;
      i_din_valid = 1'b0;
      iv_din      = '0;
      i_ready     = 1'b0;
      model_reset();
      #12;
      check_all("reset");
      chk("reset.dout", 32'(ov_dout), 32'h0);
      i_rst_n = 1'b1;

      // Single-sample latency.
      step("lat.wr", 1'b1, 1'b1, 24'h000001, 1'b0);
      chk("lat.not_yet_valid", 32'(o_dout_valid), 32'h0);
      step("lat.present", 1'b1, 1'b0, '0, 1'b0);
      chk("lat.dout", 32'(ov_dout), 32'h000001);
      chk("lat.level", 32'(ov_level), 32'h0);
      step("lat.consume", 1'b1, 1'b0, '0, 1'b1);
      step("lat.idle_ready", 1'b1, 1'b0, '0, 1'b1);

      // Back-to-back writes, slow consumer.
      for (int i = 0; i < 4; i++) step("seq.wr", 1'b1, 1'b1, DW'(24'h10 + i), 1'b0);
      for (int i = 0; i < 40; i++) step("seq.rd", 1'b1, 1'b0, '0, (i % 8) == 7);
      chk("seq.idle", 32'(o_dout_valid), 32'h0);

      // Overfill with consumer stalled.
      for (int i = 0; i < DEPTH + 4; i++)
         step("fill.wr", 1'b1, 1'b1, DW'(24'h100 + i), 1'b0);
      chk("fill.full", 32'(o_full), 32'h1);
      chk("fill.level", 32'(ov_level), 32'(DEPTH));
      chk("fill.drops", 32'(ov_drop_count), 32'd3);
      chk("fill.overflow", 32'(o_overflow), 32'h1);
      chk("fill.dout", 32'(ov_dout), 32'h100);

      // Read and write on a full memory: write is still dropped.
      step("fullrw", 1'b1, 1'b1, 24'hBADBAD, 1'b1);
      chk("fullrw.level", 32'(ov_level), 32'(DEPTH - 1));
      chk("fullrw.drops", 32'(ov_drop_count), 32'd4);
      chk("fullrw.dout", 32'(ov_dout), 32'h101);

      // Drain, then hold five samples and reset between edges.
      for (int i = 0; i < DEPTH + 2; i++) step("drain", 1'b1, 1'b0, '0, 1'b1);
      for (int i = 0; i < 5; i++) step("hold.wr", 1'b1, 1'b1, DW'(24'h200 + i), 1'b0);
      #3;
      i_rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      chk("async_rst.dout", 32'(ov_dout), 32'h0);
      #2;
      i_rst_n = 1'b1;
      step("post_rst.wr", 1'b1, 1'b1, 24'h300, 1'b0);
      step("post_rst.wr", 1'b1, 1'b1, 24'h301, 1'b0);
      step("post_rst.wr", 1'b1, 1'b1, 24'h302, 1'b0);

      // Enable low freezes everything.
      for (int i = 0; i < 10; i++) step("frozen", 1'b0, 1'b1, DW'(24'h400 + i), (i % 2) == 1);
      chk("frozen.dout", 32'(ov_dout), 32'h300);
      chk("frozen.drops", 32'(ov_drop_count), 32'd0);
      for (int i = 0; i < 8; i++) step("final.drain", 1'b1, 1'b0, '0, (i % 2) == 1);
      chk("final.idle", 32'(o_dout_valid), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
